// File: rtl/red_pitaya_iq_demodulator_block.sv
// IQ demodulator: mixes one input with the shared sin/cos LO, integrates and dumps over 2**L
// samples, rescales, saturates, and emits one decimated I/Q pair per block with a valid strobe.
module red_pitaya_iq_demodulator_block #(
  parameter int INBITS  = 14,
  parameter int SINBITS = 14,
  parameter int OUTBITS = 14,
  parameter int MAXLOG  = 10
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [INBITS-1:0]  signal_i,
  input  logic [SINBITS-1:0] sin,
  input  logic [SINBITS-1:0] cos,
  input  logic [3:0]         avg_log2_i,
  input  logic               clear_i,
  output logic [OUTBITS-1:0] i_o,
  output logic [OUTBITS-1:0] q_o,
  output logic               valid_o,
  output logic               ovf_o
);

  localparam int PW   = INBITS + SINBITS;
  localparam int ACCW = INBITS + SINBITS + MAXLOG;

  localparam logic signed [ACCW-1:0] C_OUT_MAX = ACCW'(2**(OUTBITS-1) - 1);
  localparam logic signed [ACCW-1:0] C_OUT_MIN = -C_OUT_MAX - 1;
  localparam logic [OUTBITS-1:0]     C_SAT_MAX = {1'b0, {(OUTBITS-1){1'b1}}};
  localparam logic [OUTBITS-1:0]     C_SAT_MIN = {1'b1, {(OUTBITS-1){1'b0}}};

  logic [3:0]        w_len;
  logic [MAXLOG-1:0] w_cnt_max;
  logic [5:0]        w_shamt;
  logic              w_restart;
  logic              w_dump;
  logic              w_clip;

  logic [MAXLOG-1:0] r_cnt;
  logic              r_p_vld;
  logic              r_valid;
  logic              r_ovf;
  logic [3:0]        r_last_len;

  always_comb begin
    w_len     = (avg_log2_i > 4'(MAXLOG)) ? 4'(MAXLOG) : avg_log2_i;
    w_cnt_max = MAXLOG'((32'd1 << w_len) - 32'd1);
    w_shamt   = 6'(SINBITS - 1) + {2'b00, w_len};
    // A length change restarts the block just like clear_i (ovf handling differs below).
    w_restart = clear_i | (w_len != r_last_len);
    w_dump    = r_p_vld & (r_cnt == w_cnt_max);
  end

  // Index 0 is I (signal*sin), index 1 is Q (signal*cos).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_quad
      logic [SINBITS-1:0]     w_lo;
      logic signed [ACCW-1:0] w_sum;
      logic signed [ACCW-1:0] w_shift;
      logic                   w_clip_hi;
      logic                   w_clip_lo;
      logic [OUTBITS-1:0]     w_sat;
      logic signed [PW-1:0]   r_p;
      logic signed [ACCW-1:0] r_acc;
      logic [OUTBITS-1:0]     r_out;

      assign w_lo = (gi == 0) ? sin : cos;

      always_comb begin
        w_sum     = r_acc + ACCW'(r_p);
        w_shift   = w_sum >>> w_shamt;
        w_clip_hi = (w_shift > C_OUT_MAX);
        w_clip_lo = (w_shift < C_OUT_MIN);
        if (w_clip_hi)      w_sat = C_SAT_MAX;
        else if (w_clip_lo) w_sat = C_SAT_MIN;
        else                w_sat = w_shift[OUTBITS-1:0];
      end

      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          r_p   <= '0;
          r_acc <= '0;
          r_out <= '0;
        end else begin
          r_p <= PW'($signed(signal_i)) * PW'($signed(w_lo));
          if (w_restart) begin
            r_acc <= '0;
          end else if (r_p_vld) begin
            if (w_dump) begin
              r_acc <= '0;
              r_out <= w_sat;
            end else begin
              r_acc <= w_sum;
            end
          end
        end
      end
    end
  endgenerate

  assign w_clip = g_quad[0].w_clip_hi | g_quad[0].w_clip_lo |
                  g_quad[1].w_clip_hi | g_quad[1].w_clip_lo;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt      <= '0;
      r_p_vld    <= 1'b0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_last_len <= '0;
    end else begin
      r_last_len <= w_len;
      r_valid    <= 1'b0;
      if (w_restart) begin
        // The product captured on this edge is stale; one refill cycle follows.
        r_cnt   <= '0;
        r_p_vld <= 1'b0;
        if (clear_i) r_ovf <= 1'b0;
      end else begin
        r_p_vld <= 1'b1;
        if (r_p_vld) begin
          if (w_dump) begin
            r_cnt   <= '0;
            r_valid <= 1'b1;
            if (w_clip) r_ovf <= 1'b1;
          end else begin
            r_cnt <= r_cnt + MAXLOG'(1);
          end
        end
      end
    end
  end

  assign i_o     = g_quad[0].r_out;
  assign q_o     = g_quad[1].r_out;
  assign valid_o = r_valid;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_red_pitaya_iq_demodulator_block.sv
// Directed bench for the IQ demodulator: decimation timing, scaling, saturation, clear,
// length change, clamp and asynchronous reset.
module tb_red_pitaya_iq_demodulator_block;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [13:0] signal_i;
  logic [13:0] sin;
  logic [13:0] cos;
  logic [3:0]  avg_log2_i;
  logic        clear_i;
  logic [13:0] i_o;
  logic [13:0] q_o;
  logic        valid_o;
  logic        ovf_o;

  int n_vec = 0;
  int n_bad = 0;

  red_pitaya_iq_demodulator_block dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .signal_i   (signal_i),
    .sin        (sin),
    .cos        (cos),
    .avg_log2_i (avg_log2_i),
    .clear_i    (clear_i),
    .i_o        (i_o),
    .q_o        (q_o),
    .valid_o    (valid_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expects valid_o low after each of the first n-1 edges and high after the n-th.
  task automatic wait_strobe(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      tick();
      check(tag, {31'd0, valid_o}, (k == n) ? 32'sd1 : 32'sd0);
    end
  endtask

  task automatic check_iq(input string tag, input int ei, input int eq, input int eo);
    check({tag, "_i"}, $signed(i_o), ei);
    check({tag, "_q"}, $signed(q_o), eq);
    check({tag, "_ovf"}, {31'd0, ovf_o}, eo);
  endtask

  initial begin
    rstn_i     = 1'b1;
    signal_i   = '0;
    sin        = '0;
    cos        = '0;
    avg_log2_i = 4'd0;
    clear_i    = 1'b0;
    #2 rstn_i = 1'b0;
    #1;
    check_iq("reset", 0, 0, 0);
    check("reset_valid", {31'd0, valid_o}, 0);

    // N=1: 4096*8191 >>> 13 = 4095, a strobe every cycle once the pipe has filled
    signal_i = 14'sd4096;
    sin      = 14'sd8191;
    cos      = 14'sd0;
    @(negedge clk_i) rstn_i = 1'b1;
    wait_strobe("t1_fill", 2);
    check_iq("t1", 4095, 0, 0);
    tick();
    check("t1_every", {31'd0, valid_o}, 1);

    // N=8: edge 1 restarts on the length change, edge 2 refills, edges 3..10 integrate
    avg_log2_i = 4'd3;
    signal_i   = 14'sd1000;
    cos        = -14'sd8192;
    wait_strobe("t2_first", 10);
    check_iq("t2", 999, -1000, 0);
    wait_strobe("t2_period", 8);
    check_iq("t2b", 999, -1000, 0);

    // N=1 positive overflow: 2**26 >>> 13 = 8192 clips to 8191, ovf sticks
    avg_log2_i = 4'd0;
    signal_i   = -14'sd8192;
    sin        = -14'sd8192;
    cos        = 14'sd0;
    wait_strobe("t3_strobe", 3);
    check_iq("t3", 8191, 0, 1);
    signal_i = 14'sd0;
    tick();
    tick();
    tick();
    check_iq("t3_sticky", 0, 0, 1);

    // N=8 then clear on the 5th sample of a block
    avg_log2_i = 4'd3;
    signal_i   = 14'sd1000;
    sin        = 14'sd8191;
    cos        = -14'sd8192;
    wait_strobe("t4_sync", 10);
    check_iq("t4_sync", 999, -1000, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_mid", {31'd0, valid_o}, 0);
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("t4_clr_valid", {31'd0, valid_o}, 0);
    check_iq("t4_clr_hold", 999, -1000, 0);
    wait_strobe("t4_after", 9);
    check_iq("t4", 999, -1000, 0);

    // Length 3 -> 2 mid-block: partial sum dropped, 4-sample block scaled by >>>15
    for (int k = 0; k < 3; k++) tick();
    avg_log2_i = 4'd2;
    wait_strobe("t5_len", 6);
    check_iq("t5", 999, -1000, 0);
    wait_strobe("t5_period", 4);
    check_iq("t5b", 999, -1000, 0);

    // Out-of-range length clamps to 10: 1024-sample block scaled by >>>23
    avg_log2_i = 4'd15;
    wait_strobe("t_clamp", 1026);
    check_iq("t_clamp", 999, -1000, 0);

    // Asynchronous reset in the middle of an N=8 block
    avg_log2_i = 4'd3;
    wait_strobe("t6_sync", 10);
    signal_i = 14'sd2000;
    for (int k = 0; k < 3; k++) tick();
    check_iq("t6_pre", 999, -1000, 0);
    #3 rstn_i = 1'b0;
    #1;
    check_iq("t6_rst", 0, 0, 0);
    check("t6_rst_valid", {31'd0, valid_o}, 0);
    avg_log2_i = 4'd0;
    @(negedge clk_i) rstn_i = 1'b1;
    // 2000*8191 >>> 13 = 1999, 2000*-8192 >>> 13 = -2000
    wait_strobe("t6_after", 2);
    check_iq("t6", 1999, -2000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
